lcd_tx_sched: RTL and testbench

LCD_TX_SCHED -- requirements
Module: lcd_tx_sched

---
 rtl/lcd_tx_sched_if.sv | 42 ++++
 rtl/lcd_tx_sched.sv | 156 +++++++++++++++
 tb/tb_lcd_tx_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_tx_sched_if.sv
// Bundles the three handshake channels of the LCD transmit scheduler.
//   cfg_* : init/config byte stream (command/argument bytes, packet framing)
//   pix_* : RGB565 pixel word stream
//   out_* : byte stream towards the SPI/parallel serialiser, with D/CX level
// Modports:
//   slave  : the scheduler (consumes cfg/pix, produces out)
//   master : the surrounding sources and serialiser
interface lcd_tx_sched_if;
  logic        cfg_valid;
  logic [7:0]  cfg_data;
  logic        cfg_is_cmd;
  logic        cfg_eop;
  logic        cfg_last;
  logic        cfg_ready;

  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;

  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_dc;
  logic        out_ready;

  modport slave (
    input  cfg_valid, cfg_data, cfg_is_cmd, cfg_eop, cfg_last,
    output cfg_ready,
    input  pix_valid, pix_data,
    output pix_ready,
    output out_valid, out_data, out_dc,
    input  out_ready
  );

  modport master (
    output cfg_valid, cfg_data, cfg_is_cmd, cfg_eop, cfg_last,
    input  cfg_ready,
    output pix_valid, pix_data,
    input  pix_ready,
    input  out_valid, out_data, out_dc,
    output out_ready
  );
endinterface

// File: rtl/lcd_tx_sched.sv
// LCD transmit scheduler: arbitrates between the init/config byte stream and
// the pixel stream, emitting one byte at a time to the serialiser. Config
// packets are passed straight through; each pixel frame is preceded by the
// RAMWR opcode and every RGB565 word is split into high then low byte.
// Packets and frames are never interleaved; pixels wait for init_done.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : lcd_tx_sched_if.slave (cfg_*, pix_*, out_* handshakes)
//   init_done  : sticky, set once the final init packet has been sent
//   frame_done : one-cycle pulse after the last pixel byte of a frame
//   busy       : state is not IDLE
//   frame_cnt  : completed frame count (wraps at 16 bits)
//
// Optional feature macro: LCD_TX_SCHED_FRAME_CNT_EN
//   defined   : frame_cnt counts completed frames
//   undefined : frame_cnt is tied to zero and has no flops
module lcd_tx_sched #(
  parameter int unsigned FRAME_PIXELS = 67200,
  parameter logic [7:0]  RAMWR_OPCODE = 8'h2C
) (
  input  logic              clk,
  input  logic              rst,
  lcd_tx_sched_if.slave     bus,
  output logic              init_done,
  output logic              frame_done,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned     CNT_W    = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_RAMWR,
    S_PIX_HI,
    S_PIX_LO
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] pix_cnt;
  logic             xfer_c;
  logic             frame_end_c;

  // Output decode: zero-latency pass-through of the active source
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_dc    = 1'b0;
    bus.cfg_ready = 1'b0;
    bus.pix_ready = 1'b0;
    case (state)
      S_CFG: begin
        bus.out_valid = bus.cfg_valid;
        bus.out_data  = bus.cfg_data;
        bus.out_dc    = ~bus.cfg_is_cmd;
        bus.cfg_ready = bus.out_ready;
      end
      S_RAMWR: begin
        bus.out_valid = 1'b1;
        bus.out_data  = RAMWR_OPCODE;
        bus.out_dc    = 1'b0;
      end
      S_PIX_HI: begin
        bus.out_valid = bus.pix_valid;
        bus.out_data  = bus.pix_data[15:8];
        bus.out_dc    = 1'b1;
      end
      S_PIX_LO: begin
        // The pixel word is consumed only with its second byte
        bus.out_valid = bus.pix_valid;
        bus.out_data  = bus.pix_data[7:0];
        bus.out_dc    = 1'b1;
        bus.pix_ready = bus.out_ready;
      end
      default: begin
        bus.out_valid = 1'b0;
      end
    endcase
  end

  assign xfer_c      = bus.out_valid && bus.out_ready;
  assign frame_end_c = (state == S_PIX_LO) && xfer_c && (pix_cnt == LAST_PIX);
  assign busy        = (state != S_IDLE);

  // Scheduler FSM, pixel counter and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pix_cnt    <= '0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end_c;
      case (state)
        S_IDLE: begin
          // Config always wins arbitration over pixels
          if (bus.cfg_valid) begin
            state <= S_CFG;
          end else if (bus.pix_valid && init_done) begin
            state <= S_RAMWR;
          end
        end
        S_CFG: begin
          if (xfer_c && bus.cfg_eop) begin
            state <= S_IDLE;
            if (bus.cfg_last) begin
              init_done <= 1'b1;
            end
          end
        end
        S_RAMWR: begin
          if (xfer_c) begin
            state   <= S_PIX_HI;
            pix_cnt <= '0;
          end
        end
        S_PIX_HI: begin
          if (xfer_c) begin
            state <= S_PIX_LO;
          end
        end
        S_PIX_LO: begin
          if (xfer_c) begin
            if (pix_cnt == LAST_PIX) begin
              state <= S_IDLE;
            end else begin
              pix_cnt <= pix_cnt + CNT_W'(1);
              state   <= S_PIX_HI;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LCD_TX_SCHED_FRAME_CNT_EN
  // Completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (frame_end_c) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_tx_sched.sv
// Self-checking bench for lcd_tx_sched (FRAME_PIXELS=4). Stimulus sources are
// queues of config bytes and pixel words; the expected serialiser byte stream
// is built from the packet/frame rules as items are queued, and compared
// against the bytes actually transferred.
module tb_lcd_tx_sched;

  localparam int unsigned FP  = 4;
  localparam logic [7:0]  OPC = 8'h2C;

  typedef struct packed {
    logic [7:0] data;
    logic       is_cmd;
    logic       eop;
    logic       last;
  } cfg_t;

  logic        clk;
  logic        rst;
  logic        init_done;
  logic        frame_done;
  logic        busy;
  logic [15:0] frame_cnt;

  lcd_tx_sched_if bus();

  lcd_tx_sched #(.FRAME_PIXELS(FP), .RAMWR_OPCODE(OPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .init_done  (init_done),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  cfg_t       cfg_q[$];
  logic [15:0] pix_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  bit         m_init     = 1'b0;
  int         m_frames   = 0;
  int         run_frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_fcnt();
`ifdef LCD_TX_SCHED_FRAME_CNT_EN
    return 16'(m_frames);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic push_cfg(input logic [7:0] d, input bit is_cmd, input bit eop, input bit last);
    cfg_t c;
    c.data = d; c.is_cmd = is_cmd; c.eop = eop; c.last = last;
    cfg_q.push_back(c);
    exp_q.push_back({~is_cmd, d});
    if (eop && last) m_init = 1'b1;
  endtask

  task automatic push_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    logic [15:0] p[4];
    p[0] = a; p[1] = b; p[2] = c; p[3] = d;
    exp_q.push_back({1'b0, OPC});
    for (int i = 0; i < 4; i++) begin
      pix_q.push_back(p[i]);
      exp_q.push_back({1'b1, p[i][15:8]});
      exp_q.push_back({1'b1, p[i][7:0]});
    end
    m_frames++;
    run_frames++;
  endtask

  task automatic push_rand_frame();
    push_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic push_rand_pkt();
    int len;
    len = int'($urandom_range(1, 4));
    for (int i = 0; i < len; i++)
      push_cfg(8'($urandom), (i == 0), (i == len - 1), 1'b0);
  endtask

  // bp: 0 = out_ready high, 1 = random, 2 = repeating 1,0,0,1 pattern
  task automatic run(input int max_cyc, input bit gaps, input int bp,
                     input int cfg_gate, input int abort_at);
    int         pix_fires = 0;
    int         fd_cnt    = 0;
    int         k         = 0;
    bit         prev_stall = 1'b0;
    logic [8:0] prev_byte  = '0;
    bit         cf, pf;
    bit         done    = 1'b0;
    bit         aborted = 1'b0;
    logic [3:0] pat = 4'b1001;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      @(negedge clk);
      bus.cfg_valid = (cfg_q.size() > 0) && (pix_fires >= cfg_gate) &&
                      !(gaps && $urandom_range(0, 3) == 0);
      if (cfg_q.size() > 0) begin
        bus.cfg_data   = cfg_q[0].data;
        bus.cfg_is_cmd = cfg_q[0].is_cmd;
        bus.cfg_eop    = cfg_q[0].eop;
        bus.cfg_last   = cfg_q[0].last;
      end
      bus.pix_valid = (pix_q.size() > 0) && !(gaps && $urandom_range(0, 3) == 0);
      if (pix_q.size() > 0) bus.pix_data = pix_q[0];
      case (bp)
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        2:       begin bus.out_ready = pat[3 - (k % 4)]; k++; end
        default: bus.out_ready = 1'b1;
      endcase
      #1;
      if (frame_done) fd_cnt++;
      if (prev_stall && bus.out_valid)
        chk("stall_hold", {bus.out_dc, bus.out_data}, prev_byte);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_byte  = {bus.out_dc, bus.out_data};
      if (bus.out_valid && bus.out_ready) obs_q.push_back({bus.out_dc, bus.out_data});
      cf = bus.cfg_valid && bus.cfg_ready;
      pf = bus.pix_valid && bus.pix_ready;
      if (cfg_q.size() == 0 && pix_q.size() == 0 && !busy) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        if (cf) void'(cfg_q.pop_front());
        if (pf) begin void'(pix_q.pop_front()); pix_fires++; end
        if (abort_at > 0 && obs_q.size() == abort_at) begin
          aborted = 1'b1;
          done    = 1'b1;
        end
      end
    end
    bus.cfg_valid = 1'b0;
    bus.pix_valid = 1'b0;
    if (!aborted) begin
      chk("drain", {29'd0, cfg_q.size() == 0, pix_q.size() == 0, !busy}, 32'd7);
      chk("byte_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        if (i < obs_q.size()) chk($sformatf("byte%0d", i), obs_q[i], exp_q[i]);
      chk("frame_done_pulses", fd_cnt, run_frames);
      chk("init_done", init_done, m_init);
      chk("frame_cnt", frame_cnt, exp_fcnt());
    end
    cfg_q.delete(); pix_q.delete(); exp_q.delete(); obs_q.delete();
    run_frames = 0;
  endtask

  initial begin
    rst            = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_data   = '0;
    bus.cfg_is_cmd = 1'b0;
    bus.cfg_eop    = 1'b0;
    bus.cfg_last   = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.out_ready  = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_dc", bus.out_dc, 0);
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Pixels before init must be ignored
    bus.pix_valid = 1'b1;
    bus.pix_data  = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("preinit_quiet", {bus.out_valid, bus.pix_ready, busy}, 0);
    end
    bus.pix_valid = 1'b0;

    // Init: non-final packet, then final packet
    push_cfg(8'h01, 1'b1, 1'b1, 1'b0);
    run(50, 1'b0, 0, 0, 0);
    push_cfg(8'h2A, 1'b1, 1'b0, 1'b0);
    push_cfg(8'h00, 1'b0, 1'b0, 1'b0);
    push_cfg(8'h00, 1'b0, 1'b0, 1'b0);
    push_cfg(8'h00, 1'b0, 1'b0, 1'b0);
    push_cfg(8'hF0, 1'b0, 1'b1, 1'b1);
    run(50, 1'b0, 0, 0, 0);

    // Directed frame
    push_frame(16'hF800, 16'h07E0, 16'h001F, 16'hFFFF);
    run(100, 1'b0, 0, 0, 0);

    // Config rising mid-frame waits for the frame end
    push_rand_frame();
    push_cfg(8'hB0, 1'b1, 1'b0, 1'b0);
    push_cfg(8'h11, 1'b0, 1'b1, 1'b0);
    run(100, 1'b0, 0, 2, 0);

    // Both sources valid in IDLE: config first
    push_cfg(8'h36, 1'b1, 1'b0, 1'b0);
    push_cfg(8'h00, 1'b0, 1'b1, 1'b0);
    push_frame(16'hA5C3, 16'h0F0F, 16'h8001, 16'h7FFE);
    run(100, 1'b0, 0, 0, 0);

    // Backpressure pattern 1,0,0,1
    push_frame(16'hF800, 16'h07E0, 16'h001F, 16'hFFFF);
    run(200, 1'b0, 2, 0, 0);

    // Pixel source gaps mid-frame
    push_rand_frame();
    run(300, 1'b1, 0, 0, 0);

    // Randomized mixes with gaps and backpressure
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 2))
        0:       push_rand_pkt();
        1:       push_rand_frame();
        default: begin push_rand_frame(); push_rand_frame(); end
      endcase
      run(600, 1'b1, 1, 0, 0);
    end

    // Reset in PIX_LO of the second pixel
    push_frame(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0);
    run(100, 1'b0, 0, 0, 4);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_frame_cnt", frame_cnt, 0);
    chk("midrst_frame_done", frame_done, 0);
    m_init   = 1'b0;
    m_frames = 0;
    @(negedge clk);
    rst = 1'b1;

    // Recovery: re-init and a fresh frame
    push_cfg(8'h29, 1'b1, 1'b1, 1'b1);
    run(50, 1'b0, 0, 0, 0);
    push_rand_frame();
    run(100, 1'b0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
